// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: funct3 codes, BHT counter
// encodings and the PC-to-BHT-index helper.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    // Word-aligned PC bits [idx_w+1:2] select the counter.
    function automatic int unsigned bht_idx(input logic [63:0] pc, input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch request and registered resolution result bundle.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_imm;
    logic [2:0]      ex_funct3;
    logic            ex_pred_taken;

    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [XLEN-1:0] res_redirect_pc;
    logic            res_misalign;

    modport master (
        output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_funct3, ex_pred_taken,
        input  res_valid, res_taken, res_mispredict, res_redirect_pc, res_misalign
    );

    modport slave (
        input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_funct3, ex_pred_taken,
        output res_valid, res_taken, res_mispredict, res_redirect_pc, res_misalign
    );
endinterface

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters; combinational read,
// synchronous update, all entries reset to weakly-not-taken.
module branch_bht
    import branch_pkg::*;
#(
    parameter int unsigned BHT_IDX = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BHT_IDX-1:0] rd_idx_i,
    output logic               rd_taken_o,
    input  logic               upd_en_i,
    input  logic [BHT_IDX-1:0] upd_idx_i,
    input  logic               upd_taken_i
);
    localparam int unsigned Entries = 2 ** BHT_IDX;

    logic [1:0] cnt_q [Entries];
    logic [1:0] cnt_d [Entries];

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en_i) begin
            if (upd_taken_i && cnt_q[upd_idx_i] != BHT_ST) begin
                cnt_d[upd_idx_i] = cnt_q[upd_idx_i] + 2'd1;
            end else if (!upd_taken_i && cnt_q[upd_idx_i] != BHT_SNT) begin
                cnt_d[upd_idx_i] = cnt_q[upd_idx_i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                cnt_q[i] <= BHT_WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reads the registered array, so a same-cycle update is not visible.
    assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage conditional branch resolution with BHT training and IF prediction.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned BHT_IDX = 6,
    parameter int unsigned STAT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       if_pc_i,
    output logic                  if_pred_taken_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    branch_resolve_unit_if.slave  bus
`ifdef BRU_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_branches_o,
    output logic [STAT_W-1:0]     stat_mispredicts_o
`endif
);
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("STAT_W must be at least 1");
    end

    logic            taken;
    logic            capture;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;

    logic            res_valid_q;
    logic            res_taken_q;
    logic            res_mispredict_q;
    logic [XLEN-1:0] res_redirect_pc_q;
    logic            res_misalign_q;

    always_comb begin
        taken = 1'b0;
        unique case (bus.ex_funct3)
            F3_BEQ:  taken = (bus.ex_rs1 == bus.ex_rs2);
            F3_BNE:  taken = (bus.ex_rs1 != bus.ex_rs2);
            F3_BLT:  taken = ($signed(bus.ex_rs1) < $signed(bus.ex_rs2));
            F3_BGE:  taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            F3_BLTU: taken = (bus.ex_rs1 < bus.ex_rs2);
            F3_BGEU: taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: taken = 1'b0;
        endcase
    end

    assign target  = bus.ex_pc + bus.ex_imm;
    assign seq_pc  = bus.ex_pc + XLEN'(4);
    assign capture = bus.ex_valid && !stall_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q       <= 1'b0;
            res_taken_q       <= 1'b0;
            res_mispredict_q  <= 1'b0;
            res_redirect_pc_q <= '0;
            res_misalign_q    <= 1'b0;
        end else if (flush_i) begin
            res_valid_q <= 1'b0;
        end else if (!stall_i) begin
            res_valid_q <= bus.ex_valid;
            if (bus.ex_valid) begin
                res_taken_q       <= taken;
                res_mispredict_q  <= taken != bus.ex_pred_taken;
                res_redirect_pc_q <= taken ? target : seq_pc;
                res_misalign_q    <= taken && target[1];
            end
        end
    end

    assign bus.res_valid       = res_valid_q;
    assign bus.res_taken       = res_taken_q;
    assign bus.res_mispredict  = res_mispredict_q;
    assign bus.res_redirect_pc = res_redirect_pc_q;
    assign bus.res_misalign    = res_misalign_q;

    branch_bht #(
        .BHT_IDX (BHT_IDX)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (BHT_IDX'(bht_idx(64'(if_pc_i), BHT_IDX))),
        .rd_taken_o  (if_pred_taken_o),
        .upd_en_i    (capture),
        .upd_idx_i   (BHT_IDX'(bht_idx(64'(bus.ex_pc), BHT_IDX))),
        .upd_taken_i (taken)
    );

`ifdef BRU_STATS_EN
    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (capture) begin
            if (stat_branches_q != '1) begin
                stat_branches_q <= stat_branches_q + STAT_W'(1);
            end
            if (taken != bus.ex_pred_taken && stat_mispredicts_q != '1) begin
                stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
            end
        end
    end

    assign stat_branches_o    = stat_branches_q;
    assign stat_mispredicts_o = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table with a result
// scoreboard, plus sequences for BHT training, stall/flush and reset.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred;
    logic        stall;
    logic        flush;
`ifdef BRU_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_mp;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN    (32),
        .BHT_IDX (6),
        .STAT_W  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc_i         (if_pc),
        .if_pred_taken_o (if_pred),
        .stall_i         (stall),
        .flush_i         (flush),
        .bus             (bus)
`ifdef BRU_STATS_EN
        ,
        .stat_branches_o    (stat_br),
        .stat_mispredicts_o (stat_mp)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        pred;
        logic        taken;
        logic        misp;
        logic [31:0] redir;
        logic        misal;
    } vec_t;

    typedef struct {
        logic        taken;
        logic        misp;
        logic [31:0] redir;
        logic        misal;
    } exp_t;

    vec_t vt[16];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [2:0] f3, input logic pred);
        bus.ex_valid      = 1'b1;
        bus.ex_pc         = pc;
        bus.ex_imm        = imm;
        bus.ex_rs1        = rs1;
        bus.ex_rs2        = rs2;
        bus.ex_funct3     = f3;
        bus.ex_pred_taken = pred;
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0;
    endtask

    task automatic pred_at(input logic [31:0] pc, input logic exp, input string name);
        if_pc = pc;
        #1;
        chk1(name, if_pred, exp);
    endtask

    // beq with equal (taken) or unequal (not taken) operands.
    task automatic do_branch(input logic [31:0] pc, input logic tk, input logic pred);
        drive(pc, 32'h8, 32'd1, tk ? 32'd1 : 32'd2, F3_BEQ, pred);
        step();
        idle();
    endtask

    initial begin
        vt[0]  = '{32'h100, 32'h20, 32'd5, 32'd5, F3_BEQ, 1'b0, 1'b1, 1'b1, 32'h120, 1'b0};
        vt[1]  = '{32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, F3_BLT, 1'b1, 1'b1, 1'b0, 32'h210, 1'b0};
        vt[2]  = '{32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, F3_BLTU, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0};
        vt[3]  = '{32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, F3_BGEU, 1'b0, 1'b1, 1'b1, 32'h210, 1'b0};
        vt[4]  = '{32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, F3_BGE, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0};
        vt[5]  = '{32'h300, 32'h40, 32'd3, 32'd3, F3_BNE, 1'b0, 1'b0, 1'b0, 32'h304, 1'b0};
        vt[6]  = '{32'h300, 32'hFFFFFFF0, 32'd3, 32'd4, F3_BNE, 1'b1, 1'b1, 1'b0, 32'h2F0, 1'b0};
        vt[7]  = '{32'hFFFFFFF0, 32'h20, 32'd9, 32'd9, F3_BEQ, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0};
        vt[8]  = '{32'h100, 32'h22, 32'd9, 32'd9, F3_BEQ, 1'b1, 1'b1, 1'b0, 32'h122, 1'b1};
        vt[9]  = '{32'h400, 32'h20, 32'd7, 32'd7, 3'b010, 1'b1, 1'b0, 1'b1, 32'h404, 1'b0};
        vt[10] = '{32'h400, 32'h20, 32'd7, 32'd8, 3'b011, 1'b0, 1'b0, 1'b0, 32'h404, 1'b0};
        vt[11] = '{32'hFFFFFFFC, 32'h20, 32'd7, 32'd7, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vt[12] = '{32'h100, 32'h22, 32'd9, 32'd9, F3_BNE, 1'b0, 1'b0, 1'b0, 32'h104, 1'b0};
        vt[13] = '{32'h500, 32'h8, 32'd5, 32'd5, F3_BGE, 1'b0, 1'b1, 1'b1, 32'h508, 1'b0};
        vt[14] = '{32'h500, 32'h8, 32'd5, 32'd5, F3_BLTU, 1'b0, 1'b0, 1'b0, 32'h504, 1'b0};
        vt[15] = '{32'h600, 32'h8, 32'd1, 32'hFFFFFFFF, F3_BLTU, 1'b0, 1'b1, 1'b1, 32'h608, 1'b0};

        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        if_pc = 32'h0;
        idle();
        drive(32'h0, 32'h0, 32'h0, 32'h0, F3_BEQ, 1'b0);
        idle();
        step();
        step();
        rst = 1'b0;

        chk1("reset res_valid", bus.res_valid, 1'b0);
        chk1("reset res_taken", bus.res_taken, 1'b0);
        chk1("reset res_mispredict", bus.res_mispredict, 1'b0);
        chk32("reset res_redirect_pc", bus.res_redirect_pc, 32'h0);
        chk1("reset res_misalign", bus.res_misalign, 1'b0);
        pred_at(32'h40, 1'b0, "reset pred 0x40");
`ifdef BRU_STATS_EN
        chk32("reset stat_branches", stat_br, 32'd0);
        chk32("reset stat_mispredicts", stat_mp, 32'd0);
`endif

        // Vector table, back to back.
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            drive(vt[i].pc, vt[i].imm, vt[i].rs1, vt[i].rs2, vt[i].f3, vt[i].pred);
            sb.push_back('{vt[i].taken, vt[i].misp, vt[i].redir, vt[i].misal});
            step();
            chk1($sformatf("vec%0d res_valid", i), bus.res_valid, 1'b1);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL vec%0d scoreboard empty: got 0 expected 1 entries", i);
            end else begin
                e = sb.pop_front();
                chk1($sformatf("vec%0d taken", i), bus.res_taken, e.taken);
                chk1($sformatf("vec%0d mispredict", i), bus.res_mispredict, e.misp);
                chk32($sformatf("vec%0d redirect", i), bus.res_redirect_pc, e.redir);
                chk1($sformatf("vec%0d misalign", i), bus.res_misalign, e.misal);
            end
        end
        idle();
        step();
        chk1("idle res_valid", bus.res_valid, 1'b0);

        // BHT training at 0x40 from a clean table.
        rst = 1'b1;
        step();
        rst = 1'b0;
        pred_at(32'h40, 1'b0, "bht init");
        do_branch(32'h40, 1'b1, 1'b0);
        pred_at(32'h40, 1'b1, "bht 01->10");
        pred_at(32'h140, 1'b1, "bht alias 0x140");
        pred_at(32'h44, 1'b0, "bht neighbour 0x44");
        do_branch(32'h40, 1'b1, 1'b1);
        pred_at(32'h40, 1'b1, "bht 10->11");
        do_branch(32'h40, 1'b1, 1'b1);
        do_branch(32'h40, 1'b0, 1'b1);
        pred_at(32'h40, 1'b1, "bht sat 11 then nt");
        do_branch(32'h40, 1'b0, 1'b1);
        pred_at(32'h40, 1'b0, "bht 10->01");
        do_branch(32'h40, 1'b0, 1'b0);
        do_branch(32'h40, 1'b0, 1'b0);
        do_branch(32'h40, 1'b1, 1'b0);
        pred_at(32'h40, 1'b0, "bht sat 00 then t");
        drive(32'h40, 32'h8, 32'd1, 32'd1, F3_BEQ, 1'b0);
        pred_at(32'h40, 1'b0, "bht no bypass");
        step();
        idle();
        pred_at(32'h40, 1'b1, "bht 01->10 again");

        // Stall holds results and BHT; flush kills.
        do_branch(32'h80, 1'b1, 1'b0);
        chk32("pre-stall redirect", bus.res_redirect_pc, 32'h88);
        stall = 1'b1;
        drive(32'h84, 32'h10, 32'd1, 32'd2, F3_BNE, 1'b1);
        step();
        chk1("stall res_valid", bus.res_valid, 1'b1);
        chk1("stall res_taken", bus.res_taken, 1'b1);
        chk1("stall res_mispredict", bus.res_mispredict, 1'b1);
        chk32("stall redirect", bus.res_redirect_pc, 32'h88);
        pred_at(32'h84, 1'b0, "stall bht");
        flush = 1'b1;
        step();
        chk1("flush+stall res_valid", bus.res_valid, 1'b0);
        pred_at(32'h84, 1'b0, "flush+stall bht");
        stall = 1'b0;
        step();
        chk1("flush res_valid", bus.res_valid, 1'b0);
        pred_at(32'h84, 1'b0, "flush bht");
        flush = 1'b0;
        step();
        idle();
        chk1("release res_valid", bus.res_valid, 1'b1);
        chk32("release redirect", bus.res_redirect_pc, 32'h94);
        pred_at(32'h84, 1'b1, "release bht");

        // Reset while a branch is in EX.
        drive(32'h80, 32'h8, 32'd1, 32'd1, F3_BEQ, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk1("rst res_valid", bus.res_valid, 1'b0);
        chk1("rst res_taken", bus.res_taken, 1'b0);
        chk32("rst redirect", bus.res_redirect_pc, 32'h0);
        pred_at(32'h80, 1'b0, "rst bht 0x80");
        pred_at(32'h40, 1'b0, "rst bht 0x40");
        pred_at(32'h84, 1'b0, "rst bht 0x84");
`ifdef BRU_STATS_EN
        chk32("rst stat_branches", stat_br, 32'd0);
        chk32("rst stat_mispredicts", stat_mp, 32'd0);
        do_branch(32'h200, 1'b1, 1'b1);
        do_branch(32'h204, 1'b0, 1'b1);
        do_branch(32'h208, 1'b0, 1'b0);
        step();
        chk32("stat_branches", stat_br, 32'd3);
        chk32("stat_mispredicts", stat_mp, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100000");
        $fatal(1, "timeout");
    end

endmodule
